// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the 2-wide fetch sequencer and its fetch queue.
package fetch_sequencer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst1;
    logic [31:0] inst2;
  } fq_entry_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } fseq_state_t;

  localparam logic [31:0] PAIR_BYTES = 32'd8;
  localparam logic [31:0] INST_ZERO  = 32'h0;

  // A returned pair that carries no instruction at all (empty memory).
  function automatic logic pair_is_zero(input logic [31:0] a, input logic [31:0] b);
    return (a == INST_ZERO) && (b == INST_ZERO);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-unit bus and decode valid/ready bus of the fetch sequencer.
interface fetch_sequencer_if;

  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst1;
  logic [31:0] fetch_inst2;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst1;
  logic [31:0] deq_inst2;

  modport master (
    output fetch_pc,
    input  fetch_inst1,
    input  fetch_inst2,
    output deq_valid,
    input  deq_ready,
    output deq_pc,
    output deq_inst1,
    output deq_inst2
  );

  modport slave (
    input  fetch_pc,
    output fetch_inst1,
    output fetch_inst2,
    input  deq_valid,
    output deq_ready,
    input  deq_pc,
    input  deq_inst1,
    input  deq_inst2
  );

endinterface

// File: rtl/fetch_sequencer_queue.sv
// Fetch queue: synchronous FIFO of {pc, inst1, inst2} entries with flush.
// head is zero while the queue is empty.
module fetch_queue
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fq_entry_t              push_data,
  input  logic                   pop,
  output fq_entry_t              head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t        mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry straight from storage.
  always_comb begin
    if (count_r != (AW+1)'(0)) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = '0;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch-queue controller for the 2-wide fetch unit: issues one pair
// address per cycle, queues returned pairs for decode, handles redirect and end of program.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FQ_DEPTH   = 4,
  parameter int          ZERO_LIMIT = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fetch_sequencer_if.master         bus,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic [$clog2(FQ_DEPTH):0] fq_count,
  output logic                      done
);

  localparam int            CW      = $clog2(FQ_DEPTH) + 1;
  localparam int            ZW      = $clog2(ZERO_LIMIT + 1);
  localparam logic [ZW-1:0] ZLIM    = ZW'(ZERO_LIMIT);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FQ_DEPTH);

  fseq_state_t   state_r;
  fseq_state_t   state_nxt_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   inflight_pc_r;
  logic          inflight_r;
  logic          done_r;
  logic [ZW-1:0] zero_cnt_r;

  logic          redirect_s;
  logic          deq_valid_s;
  logic          pop_s;
  logic          ret_s;
  logic          both_zero_s;
  logic          push_s;
  logic          zero_reach_s;
  logic          room_s;
  logic          issue_s;
  logic [ZW:0]   zero_sum_s;
  logic [CW:0]   occ_s;
  logic [CW-1:0] count_s;
  fq_entry_t     push_data_s;
  fq_entry_t     head_s;

  // Datapath decisions for this cycle: redirect, return, dequeue and issue.
  always_comb begin
    redirect_s   = redirect_valid && (state_r != DONE);
    deq_valid_s  = (count_s != CW'(0)) && !redirect_s;
    pop_s        = deq_valid_s && bus.deq_ready;
    ret_s        = inflight_r && !redirect_s;
    both_zero_s  = pair_is_zero(bus.fetch_inst1, bus.fetch_inst2);
    push_s       = ret_s && !both_zero_s;
    zero_sum_s   = {1'b0, zero_cnt_r} + (ZW+1)'(2);
    zero_reach_s = ret_s && both_zero_s && (zero_sum_s >= {1'b0, ZLIM});
    // The in-flight pair already owns a slot, so count it before issuing another.
    occ_s        = {1'b0, count_s} - {{CW{1'b0}}, pop_s} + {{CW{1'b0}}, inflight_r};
    room_s       = occ_s < DEPTH_W;
    issue_s      = (state_r != DONE) && !stall && !redirect_s && room_s && !zero_reach_s;
    push_data_s  = '{pc: inflight_pc_r, inst1: bus.fetch_inst1, inst2: bus.fetch_inst2};
  end

  // Sequencer next state: HOLD while issue is blocked, DONE is terminal.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN, HOLD: begin
        if (zero_reach_s) begin
          state_nxt_s = DONE;
        end else if (issue_s || redirect_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DONE:    state_nxt_s = DONE;
      default: state_nxt_s = RUN;
    endcase
  end

  // State, fetch PC and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RUN;
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0;
      done_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_r | zero_reach_s;
      if (redirect_s) begin
        fetch_pc_r <= redirect_pc & ~32'h3;
        inflight_r <= 1'b0;
      end else if (issue_s) begin
        inflight_r    <= 1'b1;
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + PAIR_BYTES;
      end else begin
        inflight_r <= 1'b0;
      end
    end
  end

  // Run length of trailing zero words seen in returned pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_r <= ZW'(0);
    end else if (redirect_s) begin
      zero_cnt_r <= ZW'(0);
    end else if (ret_s && both_zero_s) begin
      zero_cnt_r <= zero_reach_s ? ZLIM : zero_sum_s[ZW-1:0];
    end else if (ret_s) begin
      zero_cnt_r <= (bus.fetch_inst2 == INST_ZERO) ? ZW'(1) : ZW'(0);
    end else begin
      zero_cnt_r <= zero_cnt_r;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_s),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s)
  );

  assign bus.fetch_pc  = fetch_pc_r;
  assign bus.deq_valid = deq_valid_s;
  assign bus.deq_pc    = head_s.pc;
  assign bus.deq_inst1 = head_s.inst1;
  assign bus.deq_inst2 = head_s.inst2;
  assign fq_count      = count_s;
  assign done          = done_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random stall/ready/redirect traffic,
// every dequeued pair checked against a program-walk model of the instruction memory.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int          FQ_DEPTH   = 4;
  localparam int          ZERO_LIMIT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [$clog2(FQ_DEPTH):0] fq_count;
  logic        done;

  fetch_sequencer_if bus_if();

  logic [31:0] mem_w [256];
  fq_entry_t   exp_q [$];
  logic [31:0] lim_pc;
  logic        lim_hit;
  logic [31:0] exp_fpc;
  logic [31:0] tgt;
  logic        rdr;
  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  int          done_step;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .FQ_DEPTH   (FQ_DEPTH),
    .ZERO_LIMIT (ZERO_LIMIT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus_if),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fq_count       (fq_count),
    .done           (done)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_w[a[9:2]];
  endfunction

  // Fetch unit: one-cycle registered read of the pair at fetch_pc.
  always @(posedge clk) begin
    bus_if.fetch_inst1 <= rd(bus_if.fetch_pc);
    bus_if.fetch_inst2 <= rd(bus_if.fetch_pc + 32'd4);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected decode stream: walk memory from start, drop all-zero pairs, stop at the zero limit.
  task automatic build(input logic [31:0] start);
    logic [31:0] pc;
    logic [31:0] w1;
    logic [31:0] w2;
    int          zc;
    exp_q.delete();
    lim_hit = 1'b0;
    lim_pc  = 32'h0;
    pc      = start;
    zc      = 0;
    for (int i = 0; i < 400; i++) begin
      w1 = rd(pc);
      w2 = rd(pc + 32'd4);
      if (w1 == 32'h0 && w2 == 32'h0) begin
        zc = (zc + 2 > ZERO_LIMIT) ? ZERO_LIMIT : zc + 2;
        if (zc == ZERO_LIMIT) begin
          lim_hit = 1'b1;
          lim_pc  = pc;
          break;
        end
      end else begin
        exp_q.push_back('{pc: pc, inst1: w1, inst2: w2});
        zc = (w2 == 32'h0) ? 1 : 0;
      end
      pc = pc + 32'd8;
    end
  endtask

  // mode 0: all nonzero; 1: six-word program then zeros; 2: random with sparse zeros.
  task automatic fill(input int mode);
    logic prev_zero;
    int   r;
    prev_zero = 1'b0;
    for (int p = 0; p < 128; p++) begin
      mem_w[2*p]   = $urandom | 32'h1;
      mem_w[2*p+1] = $urandom | 32'h100;
      if (mode == 1) begin
        if (2*p >= 6)   mem_w[2*p]   = 32'h0;
        if (2*p+1 >= 6) mem_w[2*p+1] = 32'h0;
      end else if (mode == 2) begin
        r = $urandom_range(0, 7);
        if (r == 0 && !prev_zero) begin
          mem_w[2*p]   = 32'h0;
          mem_w[2*p+1] = 32'h0;
        end else if (r == 2) begin
          mem_w[2*p] = 32'h0;
        end else if (r == 3) begin
          mem_w[2*p+1] = 32'h0;
        end
        prev_zero = (mem_w[2*p] == 32'h0) && (mem_w[2*p+1] == 32'h0);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fetch_pc"}, bus_if.fetch_pc, RESET_PC);
    chk({tag, "_fq_count"}, 32'(fq_count), 32'd0);
    chk({tag, "_deq_valid"}, 32'(bus_if.deq_valid), 32'd0);
    chk({tag, "_deq_pc"}, bus_if.deq_pc, 32'h0);
    chk({tag, "_deq_inst"}, bus_if.deq_inst1 | bus_if.deq_inst2, 32'h0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #3;
    chk_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  // Observe the handshake just before the edge, then advance one cycle.
  task automatic tick();
    #1;
    if (bus_if.deq_valid && bus_if.deq_ready) begin
      chk("deq_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("deq_pc", bus_if.deq_pc, exp_q[0].pc);
        chk("deq_inst1", bus_if.deq_inst1, exp_q[0].inst1);
        chk("deq_inst2", bus_if.deq_inst2, exp_q[0].inst2);
        void'(exp_q.pop_front());
        delivered++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.deq_ready = 1'b1;

    // Free run: first pair two cycles after reset, one pair per cycle.
    fill(0);
    do_reset();
    build(RESET_PC);
    tick();
    chk("t1_fetch_pc0", bus_if.fetch_pc, RESET_PC + 32'd8);
    chk("t1_nodeq", 32'(bus_if.deq_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_deq_valid", 32'(bus_if.deq_valid), 32'd1);
      chk("t1_deq_pc", bus_if.deq_pc, RESET_PC + 32'(8 * k));
      chk("t1_fetch_pc", bus_if.fetch_pc, RESET_PC + 32'(8 * (k + 2)));
      chk("t1_fq_count", 32'(fq_count), 32'd1);
    end
    exp_fpc = RESET_PC + 32'd40;

    // One-cycle stall: one slot skipped, stream continues.
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("t5_pc_hold", bus_if.fetch_pc, exp_fpc);
    for (int j = 1; j <= 7; j++) begin
      tick();
      exp_fpc = exp_fpc + 32'd8;
      chk("t5_fetch_pc", bus_if.fetch_pc, exp_fpc);
      if (j == 1) chk("t5_gap", 32'(bus_if.deq_valid), 32'd0);
      if (j >= 3) chk("t5_fq_steady", 32'(fq_count), 32'd1);
    end

    // Decode blocked: queue fills to depth, PC freezes, then drains in order.
    bus_if.deq_ready = 1'b0;
    do_reset();
    build(RESET_PC);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_fq_full", 32'(fq_count), 32'(FQ_DEPTH));
    chk("t2_fetch_pc", bus_if.fetch_pc, RESET_PC + 32'(8 * FQ_DEPTH));
    chk("t2_deq_valid", 32'(bus_if.deq_valid), 32'd1);
    tick();
    chk("t2_pc_frozen", bus_if.fetch_pc, RESET_PC + 32'(8 * FQ_DEPTH));
    bus_if.deq_ready = 1'b1;
    delivered = 0;
    for (int i = 0; i < 40 && delivered < 16; i++) tick();
    chk("t2_drain", 32'(delivered), 32'd16);

    // Redirect with three entries queued and one in flight.
    fill(0);
    bus_if.deq_ready = 1'b0;
    do_reset();
    build(RESET_PC);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_fq_before", 32'(fq_count), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    #1;
    chk("t3_deq_valid_redir", 32'(bus_if.deq_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    build(32'h40);
    chk("t3_fq_flushed", 32'(fq_count), 32'd0);
    chk("t3_fetch_pc", bus_if.fetch_pc, 32'h40);
    chk("t3_deq_empty", 32'(bus_if.deq_valid), 32'd0);
    bus_if.deq_ready = 1'b1;
    tick();
    chk("t3_fetch_pc_next", bus_if.fetch_pc, 32'h48);
    tick();
    chk("t3_first_valid", 32'(bus_if.deq_valid), 32'd1);
    chk("t3_first_pc", bus_if.deq_pc, 32'h40);
    for (int i = 0; i < 4; i++) tick();

    // End of program: done when the zero run reaches the limit.
    fill(1);
    do_reset();
    build(RESET_PC);
    done_step = int'((lim_pc - RESET_PC) >> 3) + 2;
    for (int c = 1; c <= done_step + 4; c++) begin
      tick();
      chk("t4_done", 32'(done), 32'(c >= done_step));
    end
    chk("t4_fetch_stop", bus_if.fetch_pc, lim_pc + 32'd8);
    chk("t4_all_dequeued", 32'(exp_q.size()), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t4_redir_ignored", bus_if.fetch_pc, lim_pc + 32'd8);
    chk("t4_done_sticky", 32'(done), 32'd1);

    // Asynchronous reset between edges, then clean restart.
    fill(0);
    do_reset();
    build(RESET_PC);
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    do_reset();
    build(RESET_PC);
    tick();
    tick();
    chk("t6_restart_valid", 32'(bus_if.deq_valid), 32'd1);
    chk("t6_restart_pc", bus_if.deq_pc, RESET_PC);

    // Random stall, decode back-pressure and redirects.
    fill(2);
    do_reset();
    build(RESET_PC);
    delivered = 0;
    for (int c = 0; c < 300; c++) begin
      stall            = ($urandom_range(0, 3) == 0);
      bus_if.deq_ready = ($urandom_range(0, 3) != 0);
      rdr              = ($urandom_range(0, 39) == 0);
      tgt              = 32'($urandom_range(0, 1023));
      redirect_valid   = rdr;
      redirect_pc      = tgt;
      tick();
      if (rdr) build(tgt & ~32'h3);
      chk("rand_fq_bound", 32'(fq_count <= FQ_DEPTH), 32'd1);
    end
    redirect_valid   = 1'b0;
    stall            = 1'b1;
    bus_if.deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rand_drained", 32'(fq_count), 32'd0);
    chk("rand_not_done", 32'(done), 32'd0);
    chk("rand_progress", 32'(delivered > 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
